// File: rtl/matmul_pkg.sv
// Shared constants, counter widths and FSM state type for the sequential 4x4 matrix multiplier.
package matmul_pkg;
  localparam int DIM    = 4;
  localparam int N_ELEM = DIM * DIM;
  localparam int N_IN   = 2 * N_ELEM;

  localparam int LD_W  = 5;
  localparam int IJK_W = 2;
  localparam int OUT_W = 4;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    DRAIN
  } state_t;
endpackage

// File: rtl/matmul_4x4_seq_mac_unit.sv
// Combinational multiply-accumulate: full-width signed product, sign-extended, added to acc_in or to zero.
module mac_unit #(
  parameter int w         = 32,
  parameter int WIDTH_OUT = 2*w+2
) (
  input  logic                        clr,
  input  logic signed [w-1:0]         a,
  input  logic signed [w-1:0]         b,
  input  logic signed [WIDTH_OUT-1:0] acc_in,
  output logic signed [WIDTH_OUT-1:0] acc_out
);
  logic signed [2*w-1:0]       prod;
  logic signed [WIDTH_OUT-1:0] prod_ext;
  logic signed [WIDTH_OUT-1:0] base;

  always_comb begin
    prod     = a * b;
    prod_ext = WIDTH_OUT'(prod);
    base     = clr ? '0 : acc_in;
    acc_out  = base + prod_ext;
  end
endmodule

// File: rtl/matmul_4x4_seq.sv
// Sequential 4x4 signed matrix multiplier: loads A then B, runs 64 MACs on one shared unit, streams C out.
module matmul_4x4_seq
  import matmul_pkg::*;
#(
  parameter int w         = 32,
  parameter int WIDTH_OUT = 2*w+2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [w-1:0]         in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_OUT-1:0] out_data,
  output logic                        out_last,
  output logic                        busy
);
  state_t                      state_q, state_d;
  logic [LD_W-1:0]             ld_cnt_q, ld_cnt_d;
  logic [IJK_W-1:0]            i_q, i_d, j_q, j_d, k_q, k_d;
  logic [OUT_W-1:0]            out_idx_q, out_idx_d, nxt_idx;
  logic signed [WIDTH_OUT-1:0] acc_q, acc_d, mac_out;
  logic                        in_ready_q, in_ready_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [WIDTH_OUT-1:0] out_data_q, out_data_d;
  logic                        out_last_q, out_last_d;
  logic                        busy_q, busy_d;
  logic                        ld_we, c_we, in_hs, out_hs;

  logic signed [w-1:0]         a_mem_q [N_ELEM];
  logic signed [w-1:0]         b_mem_q [N_ELEM];
  logic signed [WIDTH_OUT-1:0] c_mem_q [N_ELEM];

  mac_unit #(.w(w), .WIDTH_OUT(WIDTH_OUT)) u_mac (
    .clr     (k_q == '0),
    .a       (a_mem_q[{i_q, k_q}]),
    .b       (b_mem_q[{k_q, j_q}]),
    .acc_in  (acc_q),
    .acc_out (mac_out)
  );

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    out_idx_d   = out_idx_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    ld_we       = 1'b0;
    c_we        = 1'b0;
    in_hs       = in_valid && in_ready_q;
    out_hs      = out_valid_q && out_ready;
    nxt_idx     = out_idx_q + 4'd1;

    case (state_q)
      LOAD: begin
        if (in_hs) begin
          ld_we    = 1'b1;
          ld_cnt_d = ld_cnt_q + 5'd1;
          if (ld_cnt_q == LD_W'(N_IN - 1)) begin
            ld_cnt_d   = '0;
            state_d    = COMPUTE;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
          end
        end
      end
      COMPUTE: begin
        acc_d = mac_out;
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) begin
          c_we = 1'b1;
          j_d  = j_q + 2'd1;
          if (j_q == 2'd3) begin
            i_d = i_q + 2'd1;
            // C[0] was written long ago, so the first output word can be registered now
            if (i_q == 2'd3) begin
              state_d     = DRAIN;
              out_valid_d = 1'b1;
              out_data_d  = c_mem_q[0];
              out_last_d  = 1'b0;
            end
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (out_idx_q == 4'd15) begin
            out_idx_d   = '0;
            state_d     = LOAD;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
          end else begin
            out_idx_d  = nxt_idx;
            out_data_d = c_mem_q[nxt_idx];
            out_last_d = (nxt_idx == 4'd15);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      ld_cnt_q    <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      out_idx_q   <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      out_idx_q   <= out_idx_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Matrix storage carries no reset; its contents are only read after being written by a job
  always_ff @(posedge clk) begin
    if (ld_we) begin
      if (!ld_cnt_q[4]) a_mem_q[ld_cnt_q[3:0]] <= in_data;
      else              b_mem_q[ld_cnt_q[3:0]] <= in_data;
    end
    if (c_we) c_mem_q[{i_q, j_q}] <= mac_out;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_matmul_4x4_seq.sv
// Directed bench for matmul_4x4_seq: fixed-answer jobs, backpressure, back-to-back, reset abort, random jobs.
module tb_matmul_4x4_seq;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [65:0] out_data;
  logic               out_last;
  logic               busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic signed [31:0] a_m [16];
  logic signed [31:0] b_m [16];
  logic signed [65:0] c_exp [16];

  matmul_4x4_seq #(.w(32), .WIDTH_OUT(66)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    logic signed [65:0] s, pa, pb;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int k = 0; k < 4; k++) begin
          pa = a_m[i*4+k];
          pb = b_m[k*4+j];
          s  = s + pa * pb;
        end
        c_exp[i*4+j] = s;
      end
  endtask

  // mode 0: continuous, 1: valid every other cycle, 2: random valid
  task automatic load_job(input int mode);
    int   idx   = 0;
    int   guard = 0;
    logic hs;
    while (idx < 32 && guard < 400) begin
      in_valid = (mode == 0) || (mode == 1 && guard % 2 == 0) ||
                 (mode == 2 && $urandom_range(0, 1) == 1);
      in_data  = (idx < 16) ? a_m[idx] : b_m[idx-16];
      hs       = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    chk("load_done", 66'(idx), 66'd32);
  endtask

  task automatic wait_out(input bit check_lat, input bit pulse_in);
    int cnt = 0;
    while (!out_valid && cnt < 300) begin
      if (pulse_in) begin
        in_valid = (cnt % 2 == 1);
        in_data  = 32'sh5A5A_A5A5;
      end
      if (cnt == 10) begin
        chk("compute_busy", 66'(busy), 66'd1);
        chk("compute_in_ready", 66'(in_ready), 66'd0);
      end
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    chk("out_valid_seen", 66'(out_valid), 66'd1);
    if (check_lat) chk("first_out_latency", 66'(cnt), 66'd64);
  endtask

  // mode 0: no stall, 1: 5-cycle stall on word stall_word, 2: random stalls
  task automatic drain_job(input int mode, input int stall_word);
    int          stalls;
    logic [65:0] held_d;
    logic        held_l;
    for (int wd = 0; wd < 16; wd++) begin
      stalls = (mode == 2) ? int'($urandom_range(0, 2)) : ((mode == 1 && wd == stall_word) ? 5 : 0);
      if (stalls > 0) begin
        out_ready = 1'b0;
        held_d = out_data;
        held_l = out_last;
        for (int s = 0; s < stalls; s++) begin
          @(posedge clk); #1;
          chk($sformatf("stall_data_w%0d", wd), out_data, held_d);
          chk($sformatf("stall_last_w%0d", wd), 66'(out_last), 66'(held_l));
        end
      end
      out_ready = 1'b1;
      chk($sformatf("valid_w%0d", wd), 66'(out_valid), 66'd1);
      chk($sformatf("data_w%0d", wd), out_data, c_exp[wd]);
      chk($sformatf("last_w%0d", wd), 66'(out_last), 66'(wd == 15));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("post_in_ready", 66'(in_ready), 66'd1);
    chk("post_busy", 66'(busy), 66'd0);
    chk("post_out_valid", 66'(out_valid), 66'd0);
  endtask

  initial begin
    logic signed [65:0] big_pos, big_neg;
    big_pos   = 66'sd1 <<< 64;
    big_neg   = -(66'sd1 <<< 64) + (66'sd1 <<< 33);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 66'(in_ready), 66'd1);
    chk("rst_out_valid", 66'(out_valid), 66'd0);
    chk("rst_out_data", out_data, 66'd0);
    chk("rst_out_last", 66'(out_last), 66'd0);
    chk("rst_busy", 66'(busy), 66'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // identity times ramp: C equals B = 1..16
    for (int x = 0; x < 16; x++) begin
      a_m[x]   = (x % 5 == 0) ? 32'sd1 : 32'sd0;
      b_m[x]   = 32'(x + 1);
      c_exp[x] = 66'(x + 1);
    end
    load_job(0);
    wait_out(1'b1, 1'b0);
    drain_job(0, -1);

    // most negative squared, then most negative times most positive
    for (int x = 0; x < 16; x++) begin
      a_m[x] = 32'sh8000_0000; b_m[x] = 32'sh8000_0000; c_exp[x] = big_pos;
    end
    load_job(0);
    wait_out(1'b1, 1'b0);
    drain_job(0, -1);
    for (int x = 0; x < 16; x++) begin
      b_m[x] = 32'sh7FFF_FFFF; c_exp[x] = big_neg;
    end
    load_job(0);
    wait_out(1'b1, 1'b0);
    drain_job(0, -1);

    // backpressure, ignored in_valid pulses during compute, then an immediate follow-on job
    for (int x = 0; x < 16; x++) begin
      a_m[x] = 32'(x * 3 - 20);
      b_m[x] = 32'(7 - x * x);
    end
    model();
    load_job(1);
    wait_out(1'b0, 1'b1);
    drain_job(1, 6);
    for (int x = 0; x < 16; x++) begin
      a_m[x] = 32'(1000 * x - 7777);
      b_m[x] = -32'(x * 12345);
    end
    model();
    load_job(0);
    wait_out(1'b1, 1'b0);
    drain_job(0, -1);

    // reset during compute aborts the job
    load_job(0);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 66'(in_ready), 66'd1);
    chk("abort_busy", 66'(busy), 66'd0);
    chk("abort_out_valid", 66'(out_valid), 66'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int x = 0; x < 16; x++) begin
      a_m[x] = 32'(x - 8);
      b_m[x] = 32'(x * 2 + 1);
    end
    model();
    load_job(0);
    wait_out(1'b1, 1'b0);
    drain_job(0, -1);

    // random jobs with random handshakes
    for (int r = 0; r < 4; r++) begin
      for (int x = 0; x < 16; x++) begin
        a_m[x] = $urandom();
        b_m[x] = $urandom();
      end
      model();
      load_job(2);
      wait_out(1'b0, 1'b0);
      drain_job(2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/matmul_4x4_seq.md
Name: matmul_4x4_seq

Overview:
- Sequential 4x4 signed integer matrix multiplier built around one shared multiply-accumulate unit.
- Streams A then B in over a valid/ready input port and schedules the 64 MACs of C = A*B.
- Streams C out over a valid/ready output port.
- Area-reduced alternative to the fully combinational 4x4 multiplier; results are bit-exact with it for the same w and WIDTH_OUT.

Parameters:
w, 32, signed width of every A and B element
WIDTH_OUT, 2*w+2, signed width of every C element (exact sum of four 2w-bit products)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data holds a valid element
in_ready  out  1  block accepts an element this cycle
in_data  in  w  element, signed: A row-major (16 words), then B row-major (16 words)
out_valid  out  1  out_data holds a valid C element
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  WIDTH_OUT  C element, signed, row-major order
out_last  out  1  high with C[3][3]
busy  out  1  high in COMPUTE and DRAIN

Behaviour:
- One clock; reset is asynchronous and active-low. The rst_n assertion forces state LOAD, all counters 0, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, accumulator 0. Matrix storage is not reset (don't care).
- FSM states: LOAD, COMPUTE, DRAIN.
- LOAD:
  - in_ready=1.
  - A handshake (in_valid&&in_ready) stores in_data at position ld_cnt (0..15 -> A[i][j], 16..31 -> B[i][j]) and increments ld_cnt.
  - A handshake at ld_cnt=31 moves the FSM to COMPUTE and clears ld_cnt.
  - in_valid low: no change.
- COMPUTE:
  - in_ready=0; in_valid is ignored and no data is consumed.
  - Nested counters i,j,k (k innermost), one MAC per cycle, (i,j) row-major.
  - acc_next = (k==0 ? 0 : acc) + sext(A[i][k]*B[k][j]).
  - At k=3, acc_next is written into C[i][j].
  - Exactly 64 cycles. After the cycle with i=j=k=3, the FSM moves to DRAIN.
- DRAIN:
  - out_valid=1, out_data=C[out_idx], out_last=(out_idx==15).
  - out_ready high advances out_idx.
  - While out_ready is low, out_valid, out_data and out_last are held stable.
  - A handshake at out_idx=15 moves the FSM to LOAD (in_ready=1 next cycle) and clears out_idx.
- Outside DRAIN: out_valid=0, out_data=0, out_last=0.
- Latency: if the final input handshake occurs in cycle n, out_valid is first high in cycle n+65. With continuous valid/ready, one full job takes 32+64+16=112 cycles.
- Arithmetic:
  - All signed, two's complement.
  - Each product is full 2w bits, sign-extended to WIDTH_OUT before accumulation.
  - No truncation or saturation; overflow is impossible by construction.
- Reset asserted mid-LOAD, mid-COMPUTE or mid-DRAIN aborts the job immediately. Partial results are never emitted, and the next job after reset release is correct.
- No overlap: a new load starts only after out_last is accepted.

Decomposition:
- Package matmul_pkg:
  - DIM=4, N_ELEM=16, N_IN=32.
  - Counter widths: 5-bit load counter, 2-bit i/j/k, 4-bit out index.
  - State enum typedef {LOAD, COMPUTE, DRAIN}.
- Sub-module mac_unit, parameterised on w and WIDTH_OUT. It is combinational: acc_out = (clr ? 0 : acc_in) + sext(a*b). The accumulator register lives in the controller.

Test Plan:
1. Identity and ramp: A=identity, B=ramp 1..16, continuous handshakes, out_ready=1. Required: out words 1..16 in order, out_last only on word 16, first out_valid exactly 65 cycles after the 32nd input handshake.
2. Extremes: all A=all B=-2^31 (w=32). Required: every C=2^64. Then A=-2^31, B=2^31-1. Required: every C=-2^64+2^33, matching the combinational golden values bit-exactly.
3. Backpressure:
   - in_valid toggling every other cycle, and out_ready held low for 5 cycles while word 7 is presented.
   - Required: out_data and out_last stable during the stall; no dropped or duplicated words; results equal the golden model.
   - in_valid pulses during COMPUTE: not consumed, and ld_cnt is unaffected.
4. Back-to-back jobs: a second A,B pair driven immediately after the out_last handshake. Required: in_ready=1 in the next cycle, and both result sets are correct.
5. Reset mid-operation: rst_n pulsed low at COMPUTE cycle 30. Required: in_ready=1, busy=0 and out_valid=0 immediately; after release, a fresh job yields correct C with no stale words.
6. Random regression: 1000 random signed A,B pairs read from the golden values file with random in_valid/out_ready. Required: zero mismatches versus the golden C.
